// File: rtl/led_pulse_stretcher.sv
// Stretches single-cycle event pulses into fixed-length LED flashes separated by a guaranteed off-gap.
// Latency: an event seen in IDLE lights o_led on the very next clock edge; later events are queued.
// Backpressure: none on i_evt; events beyond MAX_PEND queued are discarded and flagged on o_drop.
//
// Ports:
//   clk    - single clock, all state on its rising edge
//   rst    - asynchronous active-low reset
//   i_evt  - clean synchronous event pulse, one event per high cycle
//   o_led  - registered LED drive, high for TICK_DIV*ON_TICKS cycles per flash
//   o_busy - high whenever a flash or its trailing gap is in progress
//   o_pend - number of queued events still waiting for a flash
//   o_drop - one-cycle pulse, the cycle after an event was discarded on a full queue
module led_pulse_stretcher #(
  parameter  int TICK_DIV  = 100,
  parameter  int ON_TICKS  = 4,
  parameter  int OFF_TICKS = 4,
  parameter  int MAX_PEND  = 7,
  localparam int PEND_W    = $clog2(MAX_PEND + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_evt,
  output logic              o_led,
  output logic              o_busy,
  output logic [PEND_W-1:0] o_pend,
  output logic              o_drop
);

  // Phase lengths in clk cycles; the counter is sized for the longer one.
  localparam int ON_LEN  = TICK_DIV * ON_TICKS;
  localparam int GAP_LEN = TICK_DIV * OFF_TICKS;
  localparam int MAX_LEN = (ON_LEN > GAP_LEN) ? ON_LEN : GAP_LEN;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_LEN - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(GAP_LEN - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [PEND_W-1:0] pend;
  logic [PEND_W-1:0] pend_nxt;
  logic              drop_nxt;
  logic              led;
  logic              drop;
  logic              gap_end;

  // Last cycle of the enforced gap: the only point where the queue is drained.
  assign gap_end = (state == GAP) && (cnt == GAP_LAST);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    drop_nxt  = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (i_evt) begin
          state_nxt = ON;
        end
      end

      ON: begin
        if (cnt == ON_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      GAP: begin
        if (gap_end) begin
          cnt_nxt = '0;
          // An event arriving on the dequeue cycle is consumed directly by the
          // next flash, so the queue count is untouched and nothing can drop.
          if ((pend != '0) || i_evt) begin
            state_nxt = ON;
            if (!i_evt) begin
              pend_nxt = pend - PEND_ONE;
            end
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        pend_nxt  = '0;
      end
    endcase

    // Queue events arriving while busy, except on the dequeue cycle handled above.
    if (((state == ON) || (state == GAP)) && !gap_end && i_evt) begin
      if (pend == PEND_MAX) begin
        drop_nxt = 1'b1;
      end else begin
        pend_nxt = pend + PEND_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= '0;
      led   <= 1'b0;
      drop  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pend  <= pend_nxt;
      // LED register tracks the next state so it lights on the same edge that enters ON.
      led   <= (state_nxt == ON);
      drop  <= drop_nxt;
    end
  end

  assign o_led  = led;
  assign o_busy = (state != IDLE);
  assign o_pend = pend;
  assign o_drop = drop;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Self-checking bench for led_pulse_stretcher at default parameters.
// A flash-position reference model is compared against the DUT every cycle.
// Directed scenarios pin the model with literal counts, then a random phase runs.
module tb_led_pulse_stretcher;

  localparam int L    = 400;  // on cycles per flash
  localparam int G    = 400;  // off-gap cycles
  localparam int P    = L + G;
  localparam int MAXP = 7;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       i_evt = 1'b0;
  logic       o_led;
  logic       o_busy;
  logic [2:0] o_pend;
  logic       o_drop;

  always #5 clk = ~clk;

  led_pulse_stretcher #(
    .TICK_DIV (100),
    .ON_TICKS (4),
    .OFF_TICKS(4),
    .MAX_PEND (7)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .i_evt (i_evt),
    .o_led (o_led),
    .o_busy(o_busy),
    .o_pend(o_pend),
    .o_drop(o_drop)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: whether a flash cycle is active, position inside the
  // current on+gap window, queued event count and expected drop pulse.
  bit mact  = 1'b0;
  int mpos  = 0;
  int mpend = 0;
  bit mdrop = 1'b0;

  // Observed statistics, checked against hand-computed literals.
  int s_led, s_busy, s_drop, s_maxp, s_flash;
  int s_gmin, s_gmax, s_rmin, s_rmax;
  int cycno = 0;
  int last_fall, last_rise;
  bit prev_led;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cycno);
    end
  endtask

  task automatic model_edge(input bit e);
    bit nd;
    nd = 1'b0;
    if (!rst) begin
      mact = 1'b0; mpos = 0; mpend = 0; mdrop = 1'b0;
      return;
    end
    if (!mact) begin
      if (e) begin
        mact = 1'b1;
        mpos = 0;
      end
    end else if (mpos == P - 1) begin
      if (mpend + int'(e) > 0) begin
        mpend = mpend + int'(e) - 1;
        mpos  = 0;
      end else begin
        mact = 1'b0;
      end
    end else begin
      mpos++;
      if (e) begin
        if (mpend < MAXP) mpend++;
        else nd = 1'b1;
      end
    end
    mdrop = nd;
  endtask

  task automatic clear_stats();
    s_led = 0; s_busy = 0; s_drop = 0; s_maxp = 0; s_flash = 0;
    s_gmin = 1000000; s_gmax = 0; s_rmin = 1000000; s_rmax = 0;
    last_fall = -1; last_rise = -1;
    prev_led = o_led;
  endtask

  task automatic cyc(input bit e);
    int gap;
    int run;
    i_evt = e;
    @(posedge clk);
    model_edge(e);
    #1;
    cycno++;
    chk("led",  int'(o_led),  int'(mact && (mpos < L)));
    chk("busy", int'(o_busy), int'(mact));
    chk("pend", int'(o_pend), mpend);
    chk("drop", int'(o_drop), int'(mdrop));
    s_led  += int'(o_led);
    s_busy += int'(o_busy);
    s_drop += int'(o_drop);
    if (int'(o_pend) > s_maxp) s_maxp = int'(o_pend);
    if (o_led && !prev_led) begin
      s_flash++;
      last_rise = cycno;
      if (last_fall >= 0) begin
        gap = cycno - last_fall;
        if (gap < s_gmin) s_gmin = gap;
        if (gap > s_gmax) s_gmax = gap;
      end
    end
    if (!o_led && prev_led) begin
      last_fall = cycno;
      if (last_rise >= 0) begin
        run = cycno - last_rise;
        if (run < s_rmin) s_rmin = run;
        if (run > s_rmax) s_rmax = run;
      end
    end
    prev_led = o_led;
  endtask

  task automatic run_idle(input string nm);
    int k;
    k = 0;
    while (mact && k < 8 * P + 20) begin
      cyc(1'b0);
      k++;
    end
    chk({nm, "_idle_timeout"}, int'(mact), 0);
  endtask

  initial begin
    int k;
    int pct;

    // Reset held from time zero with the clock running.
    #2;
    chk("rst_led",  int'(o_led),  0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_pend", int'(o_pend), 0);
    chk("rst_drop", int'(o_drop), 0);
    repeat (3) cyc(1'b1);
    rst = 1'b1;
    repeat (2) cyc(1'b0);

    // Single event from IDLE.
    clear_stats();
    cyc(1'b1);
    chk("s1_led_first", int'(o_led), 1);
    chk("s1_pend_first", int'(o_pend), 0);
    run_idle("s1");
    chk("s1_led_cycles",  s_led,  400);
    chk("s1_busy_cycles", s_busy, 800);
    chk("s1_max_pend",    s_maxp, 0);
    chk("s1_busy_end",    int'(o_busy), 0);

    // Three events ten cycles apart.
    clear_stats();
    cyc(1'b1);
    chk("s2_pend0", int'(o_pend), 0);
    repeat (9) cyc(1'b0);
    cyc(1'b1);
    chk("s2_pend1", int'(o_pend), 1);
    repeat (9) cyc(1'b0);
    cyc(1'b1);
    chk("s2_pend2", int'(o_pend), 2);
    run_idle("s2");
    chk("s2_flashes",  s_flash, 3);
    chk("s2_led",      s_led,   1200);
    chk("s2_gap_min",  s_gmin,  400);
    chk("s2_gap_max",  s_gmax,  400);

    // Start event plus ten events inside the first on phase.
    clear_stats();
    cyc(1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1);
      cyc(1'b0);
    end
    chk("s3_pend_sat", int'(o_pend), 7);
    run_idle("s3");
    chk("s3_max_pend", s_maxp,  7);
    chk("s3_drops",    s_drop,  3);
    chk("s3_flashes",  s_flash, 8);

    // Full queue with an event exactly on the dequeue cycle.
    clear_stats();
    cyc(1'b1);
    repeat (7) cyc(1'b1);
    chk("s4_pend_full", int'(o_pend), 7);
    k = 0;
    while (mpos != P - 1 && k < 2 * P) begin
      cyc(1'b0);
      k++;
    end
    chk("s4_reach_gap_end", mpos, P - 1);
    cyc(1'b1);
    chk("s4_pend_kept", int'(o_pend), 7);
    chk("s4_no_drop",   int'(o_drop), 0);
    chk("s4_led_on",    int'(o_led),  1);
    run_idle("s4");
    chk("s4_drops", s_drop, 0);

    // Asynchronous reset mid-flash with three queued events.
    cyc(1'b1);
    repeat (3) begin
      cyc(1'b1);
      cyc(1'b0);
    end
    k = 0;
    while (mpos != 149 && k < P) begin
      cyc(1'b0);
      k++;
    end
    chk("s5_pend3", int'(o_pend), 3);
    rst = 1'b0;
    #1;
    chk("s5_rst_led",  int'(o_led),  0);
    chk("s5_rst_busy", int'(o_busy), 0);
    chk("s5_rst_pend", int'(o_pend), 0);
    chk("s5_rst_drop", int'(o_drop), 0);
    mact = 1'b0; mpos = 0; mpend = 0; mdrop = 1'b0;
    repeat (3) cyc(1'b0);
    rst = 1'b1;
    clear_stats();
    cyc(1'b1);
    chk("s5_first_evt", int'(o_led), 1);
    run_idle("s5");
    chk("s5_led",     s_led,   400);
    chk("s5_flashes", s_flash, 1);

    // Randomized traffic at several event densities.
    clear_stats();
    for (int b = 0; b < 10; b++) begin
      case ($urandom_range(0, 3))
        0:       pct = 1;
        1:       pct = 5;
        2:       pct = 30;
        default: pct = 80;
      endcase
      for (int i = 0; i < 2000; i++) begin
        cyc($urandom_range(0, 99) < pct);
      end
    end
    run_idle("rand");
    if (s_flash > 1) begin
      chk("rand_gap_ge_400", int'(s_gmin >= G), 1);
      chk("rand_run_min",    s_rmin, L);
      chk("rand_run_max",    s_rmax, L);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
